prod_accum: RTL and testbench

- Sequential stage directly downstream of the 4x4 combinational multiplier.
- Consumes the 8-bit product over a valid/ready handshake and sums CNT consecutive products into a wider accumulator.
- Presents each finished group sum, with an overflow flag, on a registered valid/ready output.
- Turns the multiplier into a streaming dot-product unit for the arithmetic-tree test harness.

---
 rtl/prod_accum.sv | 105 ++++++++++
 tb/tb_prod_accum.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Product accumulator: sums CNT consecutive multiplier products per group and
// presents each group sum on a valid/ready output. Optional saturation via PROD_ACCUM_SAT_EN.
module prod_accum #(
    parameter int PW  = 8,
    parameter int AW  = 16,
    parameter int CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf
);

    localparam int CW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT - 1);

    if (AW < PW) begin : g_bad_aw
        $error("prod_accum: AW must be >= PW");
    end
    if (CNT < 1) begin : g_bad_cnt
        $error("prod_accum: CNT must be >= 1");
    end

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   wide;
    logic          accept;

    assign accept = in_valid && (state_q == ST_ACC);
    // One extra bit so the carry-out can be recorded as the overflow flag.
    assign wide   = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, in_prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
`ifdef PROD_ACCUM_SAT_EN
                    acc_d = wide[AW] ? {AW{1'b1}} : wide[AW-1:0];
`else
                    acc_d = wide[AW-1:0];
`endif
                    ovf_d = ovf_q | wide[AW];
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
        // Abort overrides everything, including a same-cycle accept or drain handshake.
        if (flush) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_ACC;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: one AW=9/CNT=4 instance and one AW=16/CNT=1 instance
// driven by the same stimulus, checked against a group-sum reference model.
module tb_prod_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_prod = 8'd0;

    logic       rdy_a, vld_a, ovf_a;
    logic [8:0] sum_a;
    logic       rdy_b, vld_b, ovf_b;
    logic [15:0] sum_b;

    prod_accum #(.PW(8), .AW(9), .CNT(4)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a), .in_prod(in_prod),
        .out_valid(vld_a), .out_ready(out_ready), .out_sum(sum_a), .out_ovf(ovf_a)
    );

    prod_accum #(.PW(8), .AW(16), .CNT(1)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_b), .in_prod(in_prod),
        .out_valid(vld_b), .out_ready(out_ready), .out_sum(sum_b), .out_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        bit     ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_err = 0;
    int   n_chk = 0;

    // Reference model: products accepted so far in the group and their plain integer sum.
    longint m_sum[2];
    int     m_n[2];
    bit     m_pend[2];
    longint n_sum[2];
    int     n_n[2];
    bit     n_pend[2];
    bit     n_push[2];
    bit     n_drop[2];

    function automatic int aw_of(input int i);
        return (i == 0) ? 9 : 16;
    endfunction

    function automatic int cnt_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic exp_t expect_of(input longint s, input int aw);
        exp_t   e;
        longint lim;
        lim   = longint'(1) << aw;
        e.ovf = (s >= lim);
`ifdef PROD_ACCUM_SAT_EN
        e.sum = e.ovf ? lim - 1 : s;
`else
        e.sum = s % lim;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0; m_n[i] = 0; m_pend[i] = 1'b0;
            n_sum[i] = 0; n_n[i] = 0; n_pend[i] = 1'b0;
            n_push[i] = 1'b0; n_drop[i] = 1'b0;
        end
    endtask

    // Predict the effect of the coming clock edge under the inputs just driven.
    task automatic plan(input bit v, input logic [7:0] p, input bit f, input bit r);
        for (int i = 0; i < 2; i++) begin
            n_sum[i] = m_sum[i]; n_n[i] = m_n[i]; n_pend[i] = m_pend[i];
            n_push[i] = 1'b0; n_drop[i] = 1'b0;
            if (f) begin
                n_drop[i] = m_pend[i];
                n_sum[i] = 0; n_n[i] = 0; n_pend[i] = 1'b0;
            end else if (m_pend[i]) begin
                if (r) begin
                    n_pend[i] = 1'b0;
                    n_sum[i]  = 0;
                end
            end else if (v) begin
                n_sum[i] = m_sum[i] + longint'(p);
                n_n[i]   = m_n[i] + 1;
                if (n_n[i] == cnt_of(i)) begin
                    n_n[i]    = 0;
                    n_pend[i] = 1'b1;
                    n_push[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic commit();
        for (int i = 0; i < 2; i++) begin
            if (n_drop[i]) begin
                if (i == 0 && qa.size() > 0) void'(qa.pop_front());
                if (i == 1 && qb.size() > 0) void'(qb.pop_front());
            end
            if (n_push[i]) begin
                if (i == 0) qa.push_back(expect_of(n_sum[i], aw_of(i)));
                else        qb.push_back(expect_of(n_sum[i], aw_of(i)));
            end
            m_sum[i] = n_sum[i]; m_n[i] = n_n[i]; m_pend[i] = n_pend[i];
            n_push[i] = 1'b0; n_drop[i] = 1'b0;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] p, input bit f, input bit r);
        @(posedge clk);
        #1;
        commit();
        in_valid  = v;
        in_prod   = v ? p : 8'bx;
        flush     = f;
        out_ready = r;
        plan(v, p, f, r);
    endtask

    task automatic group4(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input bit r);
        step(1'b1, a, 1'b0, r);
        step(1'b1, b, 1'b0, r);
        step(1'b1, c, 1'b0, r);
        step(1'b1, d, 1'b0, r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " out_valid_a"}, vld_a, 0);
        chk({tag, " out_sum_a"},   sum_a, 0);
        chk({tag, " out_ovf_a"},   ovf_a, 0);
        chk({tag, " in_ready_a"},  rdy_a, 1);
        chk({tag, " out_valid_b"}, vld_b, 0);
        chk({tag, " out_sum_b"},   sum_b, 0);
        chk({tag, " out_ovf_b"},   ovf_b, 0);
        chk({tag, " in_ready_b"},  rdy_b, 1);
    endtask

    // Asynchronous reset asserted between clock edges, mid-group.
    task automatic reset_mid();
        @(posedge clk);
        #1;
        commit();
        in_valid  = 1'b0;
        in_prod   = 8'bx;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_cleared("mid_reset");
        model_clear();
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic mon_inst(input int i);
        logic   r, v, o;
        longint s;
        int     qs;
        exp_t   e;
        if (i == 0) begin r = rdy_a; v = vld_a; o = ovf_a; s = longint'(sum_a); qs = qa.size(); end
        else        begin r = rdy_b; v = vld_b; o = ovf_b; s = longint'(sum_b); qs = qb.size(); end
        chk($sformatf("in_ready[%0d]", i), r, !m_pend[i]);
        chk($sformatf("out_valid[%0d]", i), v, m_pend[i]);
        if (v) begin
            if (qs == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_sum[%0d]: got %0d expected none at %0t", i, s, $time);
            end else begin
                e = (i == 0) ? qa[0] : qb[0];
                chk($sformatf("out_sum[%0d]", i), s, e.sum);
                chk($sformatf("out_ovf[%0d]", i), o, e.ovf);
                if (out_ready && !flush) begin
                    if (i == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) mon_inst(i);
            end
        end
    end

    initial begin
        logic [7:0] p;
        bit         v, f, r;
        model_clear();
        #3;
        check_cleared("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Overflow group on the narrow instance, single-product groups on the wide one.
        group4(8'd225, 8'd225, 8'd225, 8'd225, 1'b1);
        idle(2);

        // Backpressure holds the sum; next group starts from zero.
        group4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        idle(1);
        group4(8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        idle(2);

        step(1'b1, 8'd9, 1'b0, 1'b1);
        step(1'b1, 8'd7, 1'b0, 1'b1);
        reset_mid();
        group4(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        idle(2);

        // Flush coincident with a product discards it.
        step(1'b1, 8'd100, 1'b0, 1'b1);
        step(1'b1, 8'd100, 1'b0, 1'b1);
        step(1'b1, 8'd50, 1'b1, 1'b1);
        group4(8'd3, 8'd3, 8'd3, 8'd3, 1'b1);
        idle(2);

        // Flush while draining with out_ready high drops the sum.
        group4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        idle(2);

        step(1'b1, 8'd6, 1'b0, 1'b1);
        step(1'b1, 8'd0, 1'b0, 1'b1);
        step(1'b1, 8'd255, 1'b0, 1'b1);
        idle(3);

        for (int k = 0; k < 1500; k++) begin
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            f = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 3) != 0);
            step(v, p, f, r);
        end
        idle(6);
        @(posedge clk);
        #1;
        commit();
        chk("leftover_a", qa.size(), 0);
        chk("leftover_b", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
